exhaustive_sweep_capture: RTL

Upstream/downstream harness stage for single-output trojan-detection benchmark DUTs. Drives every N_IN-bit input vector in ascending order (0 to 2^N_IN-1) into the DUT, waits a programmable settle time and samples the 1-bit response. Builds the full truth table, counts mismatches against a golden table, and streams each (vector, response) pair to a downstream logger over a valid/ready handshake.

---
 rtl/exhaustive_sweep_capture.sv | 135 +++++++++++++
 1 files changed

// File: rtl/exhaustive_sweep_capture.sv
// rtl/exhaustive_sweep_capture.sv - exhaustive input sweep, response capture, golden compare and record streaming
module exhaustive_sweep_capture #(
  parameter int N_IN   = 5,
  parameter int SETTLE = 1
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  output logic [N_IN-1:0]      vec_out,
  input  logic                 dut_resp,
  input  logic [2**N_IN-1:0]   golden_table,
  output logic                 log_valid,
  input  logic                 log_ready,
  output logic [N_IN-1:0]      log_vec,
  output logic                 log_bit,
  output logic [2**N_IN-1:0]   truth_table,
  output logic [N_IN:0]        mismatch_count,
  output logic [N_IN-1:0]      first_mismatch_vec,
  output logic                 mismatch_seen,
  output logic                 busy,
  output logic                 done
);

  localparam logic [N_IN-1:0] LAST_VEC    = '1;
  localparam logic [3:0]      SETTLE_INIT = 4'(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [N_IN-1:0] vec;
  logic [3:0]      settle_cnt;

  assign vec_out = vec;

  // State register; reset returns the sweep to IDLE.
  always_ff @(posedge CK) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: settle, sample once, then hold the record until accepted.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt <= 4'd1) state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_next = S_EMIT;
      end
      S_EMIT: begin
        if (log_ready) state_next = (vec == LAST_VEC) ? S_DONE : S_SETTLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: vector stepping, truth table capture, golden compare and log record.
  always_ff @(posedge CK) begin
    if (reset) begin
      vec                <= '0;
      settle_cnt         <= '0;
      truth_table        <= '0;
      mismatch_count     <= '0;
      first_mismatch_vec <= '0;
      mismatch_seen      <= 1'b0;
      log_valid          <= 1'b0;
      log_vec            <= '0;
      log_bit            <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec                <= '0;
            settle_cnt         <= SETTLE_INIT;
            truth_table        <= '0;
            mismatch_count     <= '0;
            first_mismatch_vec <= '0;
            mismatch_seen      <= 1'b0;
            done               <= 1'b0;
            busy               <= 1'b1;
          end
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
        end
        S_CAPTURE: begin
          truth_table[vec] <= dut_resp;
          if (dut_resp != golden_table[vec]) begin
            mismatch_count <= mismatch_count + 1'b1;
            if (!mismatch_seen) begin
              first_mismatch_vec <= vec;
              mismatch_seen      <= 1'b1;
            end
          end
          log_vec   <= vec;
          log_bit   <= dut_resp;
          log_valid <= 1'b1;
        end
        S_EMIT: begin
          if (log_ready) begin
            log_valid <= 1'b0;
            if (vec == LAST_VEC) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              vec        <= vec + 1'b1;
              settle_cnt <= SETTLE_INIT;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
